// File: rtl/spi_pkg.sv
// Shared definitions for the SPI controller: FSM states, data width, SPI mode.
package spi_pkg;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned BIT_W  = $clog2(DATA_W);

    // Mode 0: CPOL=0 (SCK idles low), CPHA=0 (sample on leading edge)
    localparam logic [1:0] SPI_MODE = 2'd0;
    localparam logic       CPOL     = SPI_MODE[1];

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_SHIFT,
        ST_HOLD,
        ST_DONE
    } state_t;

endpackage

// File: rtl/spi_sck_gen.sv
// SCK divider: counts CLK_DIV cycles per half-period while enabled.
// Ports: clk/rst, en (run divider), sck_en (allow SCK toggling),
//        sck (registered serial clock), tick_c (half-period boundary),
//        rise_c/fall_c (SCK about to go high/low on the next edge).
module spi_sck_gen
    import spi_pkg::*;
#(
    parameter int unsigned CLK_DIV = 4
)
(
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic sck_en,
    output logic sck,
    output logic tick_c,
    output logic rise_c,
    output logic fall_c
);

    localparam int unsigned CNT_W = 8;

    logic [CNT_W-1:0] cnt;

    assign tick_c = en && (cnt == CNT_W'(CLK_DIV - 1));
    assign rise_c = tick_c && sck_en && (sck == CPOL);
    assign fall_c = tick_c && sck_en && (sck != CPOL);

    // Divider restarts from zero whenever disabled so SETUP always gets a full half-period
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
            sck <= CPOL;
        end else if (!en) begin
            cnt <= '0;
            sck <= CPOL;
        end else begin
            if (tick_c) cnt <= '0;
            else        cnt <= cnt + CNT_W'(1);
            if (rise_c || fall_c) sck <= ~sck;
        end
    end

endmodule

// File: rtl/spi_controller.sv
// SPI mode-0 controller: one 8-bit full-duplex transfer per start in IDLE.
// Ports: CLK/RST, start, tx_data (MSB first) in; rx_data, busy, done,
//        counter (current bit index) out; SCK, CS_N, COPI out, POCI in.
module spi_controller
    import spi_pkg::*;
#(
    parameter int unsigned CLK_DIV = 4
)
(
    input  logic              CLK,
    input  logic              RST,
    input  logic              start,
    input  logic [DATA_W-1:0] tx_data,
    output logic [DATA_W-1:0] rx_data,
    output logic              busy,
    output logic              done,
    output logic              SCK,
    output logic              CS_N,
    output logic              COPI,
    input  logic              POCI,
    output logic [BIT_W-1:0]  counter
);

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   tx_q, tx_d;
    logic [DATA_W-1:0]   rx_q, rx_d;
    logic [DATA_W-1:0]   rx_data_d;
    logic [BIT_W-1:0]    counter_d;
    logic                copi_d, cs_n_d, busy_d, done_d;
    logic                gen_en, sck_en;
    logic                tick_c, rise_c, fall_c;

    spi_sck_gen #(.CLK_DIV(CLK_DIV)) u_sck_gen (
        .clk    (CLK),
        .rst    (RST),
        .en     (gen_en),
        .sck_en (sck_en),
        .sck    (SCK),
        .tick_c (tick_c),
        .rise_c (rise_c),
        .fall_c (fall_c)
    );

    // Next-state and next-output logic
    always_comb begin
        state_d   = state_q;
        tx_d      = tx_q;
        rx_d      = rx_q;
        rx_data_d = rx_data;
        counter_d = counter;
        copi_d    = COPI;
        cs_n_d    = CS_N;
        busy_d    = busy;
        done_d    = 1'b0;
        gen_en    = 1'b0;
        sck_en    = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d   = ST_SETUP;
                    tx_d      = tx_data;
                    rx_d      = '0;
                    copi_d    = tx_data[DATA_W-1];
                    cs_n_d    = 1'b0;
                    busy_d    = 1'b1;
                    counter_d = BIT_W'(DATA_W - 1);
                end
            end
            ST_SETUP: begin
                gen_en = 1'b1;
                if (tick_c) state_d = ST_SHIFT;
            end
            ST_SHIFT: begin
                gen_en = 1'b1;
                sck_en = 1'b1;
                if (rise_c) rx_d = {rx_q[DATA_W-2:0], POCI};
                // Counter reaching zero marks the last falling edge; COPI keeps the LSB
                if (fall_c) begin
                    if (counter == '0) begin
                        state_d = ST_HOLD;
                    end else begin
                        tx_d      = tx_q << 1;
                        copi_d    = tx_q[DATA_W-2];
                        counter_d = counter - BIT_W'(1);
                    end
                end
            end
            ST_HOLD: begin
                gen_en = 1'b1;
                if (tick_c) begin
                    state_d = ST_DONE;
                    cs_n_d  = 1'b1;
                end
            end
            ST_DONE: begin
                state_d   = ST_IDLE;
                done_d    = 1'b1;
                busy_d    = 1'b0;
                rx_data_d = rx_q;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and registered outputs
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= ST_IDLE;
            tx_q    <= '0;
            rx_q    <= '0;
            rx_data <= '0;
            counter <= '0;
            COPI    <= 1'b0;
            CS_N    <= 1'b1;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state_q <= state_d;
            tx_q    <= tx_d;
            rx_q    <= rx_d;
            rx_data <= rx_data_d;
            counter <= counter_d;
            COPI    <= copi_d;
            CS_N    <= cs_n_d;
            busy    <= busy_d;
            done    <= done_d;
        end
    end

endmodule

// File: tb/tb_spi_controller.sv
// Scoreboard bench: one instance at CLK_DIV=4, one at CLK_DIV=1.
module tb_spi_controller;

    localparam int LAT4 = 73;   // 18*4+1
    localparam int LAT1 = 19;   // 18*1+1

    typedef struct {
        logic [7:0] rx;
        int         cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   nvec = 0;
    int   nerr = 0;

    // CLK_DIV=4 instance signals
    logic       start4 = 1'b0, loop4 = 1'b1;
    logic [7:0] tx4 = 8'h00, rx_data4;
    logic       busy4, done4, sck4, cs_n4, copi4, poci4;
    logic [2:0] counter4;
    // CLK_DIV=1 instance signals
    logic       start1 = 1'b0;
    logic [7:0] tx1 = 8'h00, rx_data1;
    logic       busy1, done1, sck1, cs_n1, copi1;
    logic [2:0] counter1;

    // Peripheral model for the DIV4 instance
    logic [7:0] p_byte = 8'h55;
    logic [2:0] p_idx = 3'd7;
    logic [7:0] copi_cap = 8'h00;
    int         rise_cnt4 = 0;
    int         sckcs_viol = 0;

    exp_t sb4[$];
    exp_t sb1[$];
    exp_t e4, e1;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    spi_controller #(.CLK_DIV(4)) u_dut4 (
        .CLK(clk), .RST(rst), .start(start4), .tx_data(tx4), .rx_data(rx_data4),
        .busy(busy4), .done(done4), .SCK(sck4), .CS_N(cs_n4), .COPI(copi4),
        .POCI(poci4), .counter(counter4)
    );

    spi_controller #(.CLK_DIV(1)) u_dut1 (
        .CLK(clk), .RST(rst), .start(start1), .tx_data(tx1), .rx_data(rx_data1),
        .busy(busy1), .done(done1), .SCK(sck1), .CS_N(cs_n1), .COPI(copi1),
        .POCI(copi1), .counter(counter1)
    );

    assign poci4 = loop4 ? copi4 : p_byte[p_idx];

    // Mode-0 peripheral: MSB ready at select, next bit after each SCK fall
    always @(negedge cs_n4) begin
        p_idx     = 3'd7;
        rise_cnt4 = 0;
        copi_cap  = 8'h00;
    end
    always @(negedge sck4) if (p_idx != 3'd0) p_idx = p_idx - 3'd1;
    always @(posedge sck4) begin
        copi_cap  = {copi_cap[6:0], copi4};
        rise_cnt4 = rise_cnt4 + 1;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        nvec++;
        if (act !== req) begin
            nerr++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    // Monitors: every done pulse must match the head of its scoreboard
    always @(negedge clk) begin
        if (sck4 && cs_n4) sckcs_viol++;
        if (sck1 && cs_n1) sckcs_viol++;
        if (done4) begin
            chk("done4_expected", 32'(sb4.size() != 0), 32'd1);
            if (sb4.size() != 0) begin
                e4 = sb4.pop_front();
                chk("rx_data4", 32'(rx_data4), 32'(e4.rx));
                chk("done4_cycle", 32'(cyc), 32'(e4.cyc));
            end
        end
        if (done1) begin
            chk("done1_expected", 32'(sb1.size() != 0), 32'd1);
            if (sb1.size() != 0) begin
                e1 = sb1.pop_front();
                chk("rx_data1", 32'(rx_data1), 32'(e1.rx));
                chk("done1_cycle", 32'(cyc), 32'(e1.cyc));
            end
        end
    end

    task automatic wait_idle4(input string nm);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((busy4 || sb4.size() != 0) && n < 400);
        @(negedge clk);
        chk(nm, 32'(busy4 || sb4.size() != 0), 32'd0);
    endtask

    task automatic xfer4(input logic [7:0] tx, input logic lp, input logic [7:0] exp_rx,
                         input int extra_at, input string nm);
        exp_t e;
        @(negedge clk);
        loop4  = lp;
        tx4    = tx;
        start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        tx4    = ~tx;
        e.rx   = exp_rx;
        e.cyc  = cyc + LAT4;
        sb4.push_back(e);
        chk({nm, "_accept"}, 32'({busy4, cs_n4, copi4, counter4}), 32'({1'b1, 1'b0, tx[7], 3'd7}));
        if (extra_at > 0) begin
            repeat (extra_at - 1) @(negedge clk);
            start4 = 1'b1;
            @(negedge clk);
            start4 = 1'b0;
        end
        wait_idle4({nm, "_timeout"});
        chk({nm, "_rises"}, 32'(rise_cnt4), 32'd8);
        chk({nm, "_copi_bits"}, 32'(copi_cap), 32'(tx));
    endtask

    initial begin
        exp_t e;
        int   n1;
        int   n;
        repeat (3) @(negedge clk);
        chk("reset4", 32'({sck4, cs_n4, copi4, busy4, done4, counter4, rx_data4}),
            32'({1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00}));
        chk("reset1", 32'({sck1, cs_n1, copi1, busy1, done1, counter1, rx_data1}),
            32'({1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00}));
        rst = 1'b0;
        repeat (2) @(negedge clk);

        xfer4(8'hA5, 1'b1, 8'hA5, 0, "loop_a5");
        p_byte = 8'h55;
        xfer4(8'hAA, 1'b0, 8'h55, 0, "poci_55");
        xfer4(8'h96, 1'b1, 8'h96, 10, "restart_ignored");

        // Abort after the 4th SCK rising edge
        @(negedge clk);
        loop4 = 1'b1; tx4 = 8'hC3; start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        e.rx = 8'hC3; e.cyc = cyc + LAT4;
        sb4.push_back(e);
        n = 0;
        while (rise_cnt4 < 4 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("abort_wait_timeout", 32'(rise_cnt4), 32'd4);
        rst = 1'b1;
        #1;
        chk("abort_pins", 32'({sck4, cs_n4, busy4, rx_data4}), 32'({1'b0, 1'b1, 1'b0, 8'h00}));
        sb4.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (90) @(negedge clk);
        chk("abort_rx_kept_zero", 32'(rx_data4), 32'h00);
        xfer4(8'h3C, 1'b1, 8'h3C, 0, "after_abort");

        // CLK_DIV=1 back-to-back with start held high
        @(negedge clk);
        tx1 = 8'hFF; start1 = 1'b1;
        @(negedge clk);
        n1 = cyc;
        e.rx = 8'hFF; e.cyc = n1 + LAT1;
        sb1.push_back(e);
        chk("div1_accept1", 32'({busy1, cs_n1, copi1, counter1}), 32'({1'b1, 1'b0, 1'b1, 3'd7}));
        repeat (5) @(negedge clk);
        tx1 = 8'h00;
        repeat (15) @(negedge clk);
        start1 = 1'b0;
        e.rx = 8'h00; e.cyc = n1 + 20 + LAT1;
        sb1.push_back(e);
        chk("div1_accept2", 32'({busy1, cs_n1, copi1, counter1}), 32'({1'b1, 1'b0, 1'b0, 3'd7}));
        n = 0;
        while ((busy1 || sb1.size() != 0) && n < 100) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        chk("div1_timeout", 32'(busy1 || sb1.size() != 0), 32'd0);

        chk("sck_while_cs_high", 32'(sckcs_viol), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/spi_controller.md
SPI_CONTROLLER -- requirements
Module: spi_controller

Interface
REQ-001 The block SHALL have parameter CLK_DIV, default 4, meaning SCK half-period in CLK cycles; legal range 1..255.
REQ-002 The block SHALL have port CLK, input, 1 bit: the single system clock, rising-edge active.
REQ-003 The block SHALL have port RST, input, 1 bit: reset, asynchronous and active-high.
REQ-004 The block SHALL have port start, input, 1 bit: request one 8-bit transfer; sampled only in IDLE.
REQ-005 The block SHALL have port tx_data, input, 8 bits: byte to send MSB-first; captured on the accepting edge.
REQ-006 The block SHALL have port rx_data, output, 8 bits: last received byte; held until the next done.
REQ-007 The block SHALL have port busy, output, 1 bit: high from the accepting edge until done.
REQ-008 The block SHALL have port done, output, 1 bit: one-CLK pulse when a transfer completes.
REQ-009 The block SHALL have port SCK, output, 1 bit: serial clock, mode 0 (idles low).
REQ-010 The block SHALL have port CS_N, output, 1 bit: active-low peripheral select.
REQ-011 The block SHALL have port COPI, output, 1 bit: serial data to the peripheral.
REQ-012 The block SHALL have port POCI, input, 1 bit: serial data from the peripheral.
REQ-013 The block SHALL have port counter, output, 3 bits: index of the current bit, 7 down to 0.

Function
REQ-014 The FSM SHALL have states IDLE, SETUP, SHIFT, HOLD, DONE; no other states are reachable.
REQ-015 IDLE with start=1: latch tx_data into the shift register, CS_N=0, busy=1, COPI=tx_data[7], counter=7, go to SETUP.
REQ-016 SETUP SHALL last CLK_DIV cycles with SCK low, then go to SHIFT.
REQ-017 SHIFT SHALL toggle SCK every CLK_DIV cycles and produce exactly 8 rising and 8 falling edges.
REQ-018 On each SCK rising edge, POCI SHALL be sampled into the LSB of the receive shift register.
REQ-019 On each of the first 7 SCK falling edges, the transmit register SHALL shift left, COPI SHALL present the next bit, and counter SHALL decrement.
REQ-020 On the 8th SCK falling edge, SCK SHALL remain low and the FSM SHALL go to HOLD; COPI holds the LSB.
REQ-021 HOLD SHALL last CLK_DIV cycles, then go to DONE with CS_N=1.
REQ-022 DONE SHALL last one cycle: done=1, rx_data updated, busy=0 on exit, then return to IDLE.
REQ-023 Latency from the start-accepting edge to the done rising edge SHALL be 18*CLK_DIV+1 CLK cycles.
REQ-024 start asserted while busy=1 SHALL be ignored and not queued.
REQ-025 start held high in the DONE cycle SHALL be ignored; start in the following IDLE cycle SHALL begin a new transfer with no SCK edge in between.
REQ-026 tx_data changes after the accepting edge SHALL NOT affect the byte in flight.
REQ-027 CS_N SHALL change only while SCK is low.
REQ-028 SCK SHALL never toggle while CS_N=1.
REQ-029 CLK_DIV=1 SHALL yield SCK=CLK/2 with all rules above unchanged.

Reset
REQ-030 RST=1 SHALL asynchronously force IDLE, SCK=0, CS_N=1, COPI=0, busy=0, done=0, counter=0, rx_data=8'h00, and clear the internal divider and shift registers.
REQ-031 RST asserted mid-transfer SHALL abort the transfer without a done pulse and leave rx_data at 8'h00.
REQ-032 After RST deasserts, the first start SHALL behave exactly as in REQ-015.

Structure
REQ-033 A shared package spi_pkg SHALL hold the FSM state enum, DATA_W=8, and the SPI mode constant.
REQ-034 A single sub-module spi_sck_gen SHALL hold the CLK_DIV divider and produce SCK plus rise/fall strobes, enabled by the FSM.

Verification
REQ-035 Loopback COPI->POCI, tx_data=8'hA5, CLK_DIV=4 -> rx_data=8'hA5 and done exactly 73 cycles after start.
REQ-036 tx_data=8'hAA, POCI model driving 8'h55 MSB-first on SCK falling edges -> COPI bit sequence 1,0,1,0,1,0,1,0 at rising edges, and rx_data=8'h55.
REQ-037 start pulsed at cycle 10 of a transfer -> no second transfer, exactly 8 SCK rising edges, and a single done pulse.
REQ-038 RST pulsed after the 4th SCK rising edge -> immediate CS_N=1 and SCK=0, no done pulse, rx_data=8'h00; the next transfer of 8'h3C completes correctly.
REQ-039 CLK_DIV=1, back-to-back transfers 8'hFF then 8'h00 with start held high -> two done pulses 20 cycles apart and the correct rx_data for each.
